// File: rtl/motor_pwm_ramp.sv
// Two-channel H-bridge PWM stage with slew-limited duty and coast dead-time on reversal.
// Channels share the prescaler/PWM counter; all duty and direction changes land on the period boundary.
module motor_pwm_ramp #(
  parameter int PRESCALE  = 390,
  parameter int RAMP_STEP = 8,
  parameter int DEAD_PER  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run_en,
  input  logic [7:0] duty_a,
  input  logic       dir_a,
  input  logic [7:0] duty_b,
  input  logic       dir_b,
  output logic       enableA,
  output logic       enableB,
  output logic       JA1,
  output logic       JA2,
  output logic       JA3,
  output logic       JA4,
  output logic [7:0] cur_a,
  output logic [7:0] cur_b,
  output logic       busy
);

  localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [7:0]    STEP      = 8'(RAMP_STEP);
  localparam logic [7:0]    DEAD_LAST = 8'(DEAD_PER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DOWN = 2'd2,
    DEAD = 2'd3
  } state_t;

  logic [PW-1:0]   presc_r;
  logic [7:0]      pcnt_r;
  logic            tick_s;
  logic            pb_s;

  state_t          state_r    [2];
  state_t          state_nx_s [2];
  logic [1:0][7:0] cur_r;
  logic [1:0][7:0] cur_nx_s;
  logic [1:0][7:0] dcnt_r;
  logic [1:0][7:0] dcnt_nx_s;
  logic [1:0]      dirl_r;
  logic [1:0]      dirl_nx_s;
  logic [1:0][1:0] pins_r;
  logic [1:0][1:0] pins_nx_s;
  logic [1:0]      en_r;
  logic [1:0]      busy_ch_s;
  logic            busy_r;
  logic [1:0][7:0] tgt_s;
  logic [1:0]      dir_s;

  function automatic logic [7:0] sat_sub(input logic [7:0] v);
    return (v > STEP) ? (v - STEP) : 8'd0;
  endfunction

  // Move toward t by at most STEP without overshooting.
  function automatic logic [7:0] ramp_to(input logic [7:0] v, input logic [7:0] t);
    logic [7:0] r;
    if (t > v) begin
      r = ((t - v) > STEP) ? (v + STEP) : t;
    end else begin
      r = ((v - t) > STEP) ? (v - STEP) : t;
    end
    return r;
  endfunction

  assign tick_s   = (presc_r == PRE_LAST);
  assign pb_s     = tick_s && (pcnt_r == 8'd254);
  assign tgt_s[0] = run_en ? duty_a : 8'd0;
  assign tgt_s[1] = run_en ? duty_b : 8'd0;
  assign dir_s    = {dir_b, dir_a};

  // Shared prescaler and 0..254 PWM counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_r <= '0;
      pcnt_r  <= 8'd0;
    end else begin
      presc_r <= tick_s ? '0 : (presc_r + PW'(1));
      if (tick_s) begin
        pcnt_r <= (pcnt_r == 8'd254) ? 8'd0 : (pcnt_r + 8'd1);
      end
    end
  end

  // Per-channel next state; pins and busy derive from the next-state values so they register in step.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_nx_s[i] = state_r[i];
      cur_nx_s[i]   = cur_r[i];
      dcnt_nx_s[i]  = dcnt_r[i];
      dirl_nx_s[i]  = dirl_r[i];
      if (pb_s) begin
        case (state_r[i])
          IDLE: begin
            cur_nx_s[i] = 8'd0;
            if (tgt_s[i] != 8'd0) begin
              dirl_nx_s[i]  = dir_s[i];
              state_nx_s[i] = RUN;
            end else begin
              state_nx_s[i] = IDLE;
            end
          end
          RUN: begin
            if (dir_s[i] != dirl_r[i]) begin
              cur_nx_s[i]   = sat_sub(cur_r[i]);
              state_nx_s[i] = DOWN;
            end else begin
              cur_nx_s[i] = ramp_to(cur_r[i], tgt_s[i]);
              if ((cur_nx_s[i] == 8'd0) && (tgt_s[i] == 8'd0)) begin
                state_nx_s[i] = IDLE;
              end else begin
                state_nx_s[i] = RUN;
              end
            end
          end
          DOWN: begin
            cur_nx_s[i] = sat_sub(cur_r[i]);
            if (cur_nx_s[i] == 8'd0) begin
              dcnt_nx_s[i]  = 8'd0;
              state_nx_s[i] = DEAD;
            end else begin
              state_nx_s[i] = DOWN;
            end
          end
          DEAD: begin
            cur_nx_s[i]  = 8'd0;
            dcnt_nx_s[i] = dcnt_r[i] + 8'd1;
            if (dcnt_nx_s[i] == DEAD_LAST) begin
              dirl_nx_s[i]  = dir_s[i];
              state_nx_s[i] = (tgt_s[i] != 8'd0) ? RUN : IDLE;
            end else begin
              state_nx_s[i] = DEAD;
            end
          end
          default: begin
            cur_nx_s[i]   = 8'd0;
            state_nx_s[i] = IDLE;
          end
        endcase
      end else begin
        state_nx_s[i] = state_r[i];
      end
      case (state_nx_s[i])
        RUN, DOWN: pins_nx_s[i] = dirl_nx_s[i] ? 2'b10 : 2'b01;
        default:   pins_nx_s[i] = 2'b00;
      endcase
      busy_ch_s[i] = (state_nx_s[i] == DOWN) || (state_nx_s[i] == DEAD) ||
                     ((state_nx_s[i] == RUN) && (cur_nx_s[i] != tgt_s[i]));
    end
  end

  // Channel state, applied duty, pins and PWM outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        state_r[i] <= IDLE;
      end
      cur_r  <= '0;
      dcnt_r <= '0;
      dirl_r <= 2'b11;
      pins_r <= '0;
      en_r   <= 2'b00;
      busy_r <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_r[i] <= state_nx_s[i];
        en_r[i]    <= (pcnt_r < cur_r[i]);
      end
      cur_r  <= cur_nx_s;
      dcnt_r <= dcnt_nx_s;
      dirl_r <= dirl_nx_s;
      pins_r <= pins_nx_s;
      busy_r <= |busy_ch_s;
    end
  end

  assign enableA = en_r[0];
  assign enableB = en_r[1];
  assign JA1     = pins_r[0][1];
  assign JA2     = pins_r[0][0];
  assign JA3     = pins_r[1][1];
  assign JA4     = pins_r[1][0];
  assign cur_a   = cur_r[0];
  assign cur_b   = cur_r[1];
  assign busy    = busy_r;

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// Bench for motor_pwm_ramp: per-period vector table through a scoreboard, plus hand sequences
// for PWM duty, saturation (second instance with a large step) and mid-operation reset.
module tb_motor_pwm_ramp;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       run_en = 1'b0, dir_a = 1'b1, dir_b = 1'b1;
  logic [7:0] duty_a = 8'd0, duty_b = 8'd0;
  logic       enableA, enableB, JA1, JA2, JA3, JA4, busy;
  logic [7:0] cur_a, cur_b;

  logic       run2 = 1'b0, dir2a = 1'b1, dir2b = 1'b1;
  logic [7:0] duty2a = 8'd0, duty2b = 8'd0;
  logic       en2a, en2b, j21, j22, j23, j24, busy2;
  logic [7:0] cur2a, cur2b;

  motor_pwm_ramp #(.PRESCALE(1), .RAMP_STEP(8), .DEAD_PER(4)) dut (
    .clock(clock), .reset(reset), .run_en(run_en),
    .duty_a(duty_a), .dir_a(dir_a), .duty_b(duty_b), .dir_b(dir_b),
    .enableA(enableA), .enableB(enableB),
    .JA1(JA1), .JA2(JA2), .JA3(JA3), .JA4(JA4),
    .cur_a(cur_a), .cur_b(cur_b), .busy(busy)
  );

  motor_pwm_ramp #(.PRESCALE(1), .RAMP_STEP(100), .DEAD_PER(4)) dut2 (
    .clock(clock), .reset(reset), .run_en(run2),
    .duty_a(duty2a), .dir_a(dir2a), .duty_b(duty2b), .dir_b(dir2b),
    .enableA(en2a), .enableB(en2b),
    .JA1(j21), .JA2(j22), .JA3(j23), .JA4(j24),
    .cur_a(cur2a), .cur_b(cur2b), .busy(busy2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       run;
    logic [7:0] da;
    logic       ra;
    logic [7:0] db;
    logic       rb;
    logic [7:0] ca;
    logic [1:0] pa;
    logic [7:0] cb;
    logic [1:0] pbn;
    logic       bz;
  } vec_t;

  typedef struct {
    int          idx;
    logic [20:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   ph = 0;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic void add(input logic run, input logic [7:0] da, input logic ra,
                              input logic [7:0] db, input logic rb, input logic [7:0] ca,
                              input logic [1:0] pa, input logic [7:0] cb, input logic [1:0] pbn,
                              input logic bz);
    vec_t v;
    v.run = run; v.da = da; v.ra = ra; v.db = db; v.rb = rb;
    v.ca = ca; v.pa = pa; v.cb = cb; v.pbn = pbn; v.bz = bz;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: sample point is 1 time unit after the rising edge; ph mirrors the PWM counter.
  task automatic clk1();
    @(posedge clock);
    #1;
    ph = (ph == 254) ? 0 : ph + 1;
  endtask

  task automatic to_pb();
    clk1();
    while (ph != 0) clk1();
  endtask

  task automatic run_rows(input int first, input int last);
    sb_t  s;
    sb_t  e;
    logic [20:0] act;
    for (int i = first; i <= last; i++) begin
      run_en = vecs[i].run; duty_a = vecs[i].da; dir_a = vecs[i].ra;
      duty_b = vecs[i].db;  dir_b = vecs[i].rb;
      s.idx = i;
      s.exp = {vecs[i].ca, vecs[i].pa, vecs[i].cb, vecs[i].pbn, vecs[i].bz};
      sb_q.push_back(s);
      to_pb();
      e = sb_q.pop_front();
      act = {cur_a, JA1, JA2, cur_b, JA3, JA4, busy};
      chk($sformatf("row%0d {cur_a,pins_a,cur_b,pins_b,busy}", e.idx), 32'(act), 32'(e.exp));
    end
  endtask

  task automatic count_period(output int ca, output int cb, output int c2);
    ca = 0; cb = 0; c2 = 0;
    for (int k = 0; k < 255; k++) begin
      clk1();
      ca += int'(enableA);
      cb += int'(enableB);
      c2 += int'(en2a);
    end
  endtask

  initial begin
    int   na, nb, n2;
    logic bad;

    // soft start A to 40 forward
    add(1'b1, 8'd40, 1'b1, 8'd0, 1'b1,  8'd0, 2'b10, 8'd0, 2'b00, 1'b1);
    add(1'b1, 8'd40, 1'b1, 8'd0, 1'b1,  8'd8, 2'b10, 8'd0, 2'b00, 1'b1);
    add(1'b1, 8'd40, 1'b1, 8'd0, 1'b1, 8'd16, 2'b10, 8'd0, 2'b00, 1'b1);
    add(1'b1, 8'd40, 1'b1, 8'd0, 1'b1, 8'd24, 2'b10, 8'd0, 2'b00, 1'b1);
    add(1'b1, 8'd40, 1'b1, 8'd0, 1'b1, 8'd32, 2'b10, 8'd0, 2'b00, 1'b1);
    add(1'b1, 8'd40, 1'b1, 8'd0, 1'b1, 8'd40, 2'b10, 8'd0, 2'b00, 1'b0);
    add(1'b1, 8'd40, 1'b1, 8'd0, 1'b1, 8'd40, 2'b10, 8'd0, 2'b00, 1'b0);
    // A reverses while B ramps 0->24
    add(1'b1, 8'd40, 1'b0, 8'd24, 1'b1, 8'd32, 2'b10,  8'd0, 2'b10, 1'b1);
    add(1'b1, 8'd40, 1'b0, 8'd24, 1'b1, 8'd24, 2'b10,  8'd8, 2'b10, 1'b1);
    add(1'b1, 8'd40, 1'b0, 8'd24, 1'b1, 8'd16, 2'b10, 8'd16, 2'b10, 1'b1);
    add(1'b1, 8'd40, 1'b0, 8'd24, 1'b1,  8'd8, 2'b10, 8'd24, 2'b10, 1'b1);
    add(1'b1, 8'd40, 1'b0, 8'd24, 1'b1,  8'd0, 2'b00, 8'd24, 2'b10, 1'b1);
    add(1'b1, 8'd40, 1'b0, 8'd24, 1'b1,  8'd0, 2'b00, 8'd24, 2'b10, 1'b1);
    add(1'b1, 8'd40, 1'b0, 8'd24, 1'b1,  8'd0, 2'b00, 8'd24, 2'b10, 1'b1);
    add(1'b1, 8'd40, 1'b0, 8'd24, 1'b1,  8'd0, 2'b00, 8'd24, 2'b10, 1'b1);
    add(1'b1, 8'd40, 1'b0, 8'd24, 1'b1,  8'd0, 2'b01, 8'd24, 2'b10, 1'b1);
    add(1'b1, 8'd40, 1'b0, 8'd24, 1'b1,  8'd8, 2'b01, 8'd24, 2'b10, 1'b1);
    add(1'b1, 8'd40, 1'b0, 8'd24, 1'b1, 8'd16, 2'b01, 8'd24, 2'b10, 1'b1);
    add(1'b1, 8'd40, 1'b0, 8'd24, 1'b1, 8'd24, 2'b01, 8'd24, 2'b10, 1'b1);
    add(1'b1, 8'd40, 1'b0, 8'd24, 1'b1, 8'd32, 2'b01, 8'd24, 2'b10, 1'b1);
    add(1'b1, 8'd40, 1'b0, 8'd24, 1'b1, 8'd40, 2'b01, 8'd24, 2'b10, 1'b0);
    // both to 64, then run_en drop ramps both to idle
    add(1'b1, 8'd64, 1'b0, 8'd64, 1'b1, 8'd48, 2'b01, 8'd32, 2'b10, 1'b1);
    add(1'b1, 8'd64, 1'b0, 8'd64, 1'b1, 8'd56, 2'b01, 8'd40, 2'b10, 1'b1);
    add(1'b1, 8'd64, 1'b0, 8'd64, 1'b1, 8'd64, 2'b01, 8'd48, 2'b10, 1'b1);
    add(1'b1, 8'd64, 1'b0, 8'd64, 1'b1, 8'd64, 2'b01, 8'd56, 2'b10, 1'b1);
    add(1'b1, 8'd64, 1'b0, 8'd64, 1'b1, 8'd64, 2'b01, 8'd64, 2'b10, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      add(1'b0, 8'd64, 1'b0, 8'd64, 1'b1, 8'(64 - 8 * k), 2'b01, 8'(64 - 8 * k), 2'b10, 1'b1);
    end
    add(1'b0, 8'd64, 1'b0, 8'd64, 1'b1, 8'd0, 2'b00, 8'd0, 2'b00, 1'b0);
    add(1'b0, 8'd200, 1'b1, 8'd150, 1'b0, 8'd0, 2'b00, 8'd0, 2'b00, 1'b0);

    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset_state", {enableA, enableB, JA1, JA2, JA3, JA4, busy, cur_a, cur_b, 1'b0},
        {7'd0, 8'd0, 8'd0, 1'b0});
    reset = 1'b1;
    ph = 0;

    run_rows(0, 6);
    count_period(na, nb, n2);
    chk("pwm_high_clocks_a40", 32'(na), 32'd40);
    chk("pwm_high_clocks_b0", 32'(nb), 32'd0);
    chk("busy_steady_a40", 32'(busy), 32'd0);
    run_rows(7, 20);
    run_rows(21, 34);

    // saturation on the large-step instance
    run2 = 1'b1; duty2a = 8'd255; dir2a = 1'b1;
    to_pb();
    chk("sat_start {cur,pins,busy}", {cur2a, j21, j22, busy2}, {8'd0, 2'b10, 1'b1});
    to_pb();
    chk("sat_100", 32'(cur2a), 32'd100);
    to_pb();
    chk("sat_200", 32'(cur2a), 32'd200);
    to_pb();
    chk("sat_255 {cur,busy}", {cur2a, busy2}, {8'd255, 1'b0});
    count_period(na, nb, n2);
    chk("pwm_high_clocks_255", 32'(n2), 32'd255);
    duty2a = 8'd0;
    to_pb();
    chk("sat_dn_155", {cur2a, j21, j22, busy2}, {8'd155, 2'b10, 1'b1});
    to_pb();
    chk("sat_dn_55", 32'(cur2a), 32'd55);
    to_pb();
    chk("sat_dn_idle {cur,pins,busy}", {cur2a, j21, j22, busy2}, {8'd0, 2'b00, 1'b0});

    // reset mid-operation
    run_en = 1'b1; duty_a = 8'd100; dir_a = 1'b1; duty_b = 8'd50; dir_b = 1'b0;
    to_pb(); to_pb(); to_pb();
    chk("pre_reset {cur_a,pins_a,cur_b,pins_b}", {cur_a, JA1, JA2, cur_b, JA3, JA4},
        {8'd16, 2'b10, 8'd16, 2'b01});
    repeat (5) clk1();
    chk("pre_reset_enable", {enableA, enableB}, 2'b11);
    reset = 1'b0;
    #1;
    chk("reset_async_clear", {enableA, enableB, JA1, JA2, JA3, JA4, busy, cur_a, cur_b},
        {7'd0, 8'd0, 8'd0});
    duty_a = 8'd0; duty_b = 8'd0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    ph = 0;
    bad = 1'b0;
    for (int k = 0; k < 3 * 255; k++) begin
      clk1();
      if ({enableA, enableB, JA1, JA2, JA3, JA4, busy, cur_a, cur_b} != 23'd0) bad = 1'b1;
    end
    chk("post_reset_quiet_3_periods", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
